iq_fetch_ctrl: RTL and testbench

- Credit-based fetch throttle and flush-recovery sequencer for the decode-stage instruction queue (IQ).
- Sits between the fetch unit and the IQ.
- Issues fetch requests only when the IQ can absorb worst-case returns.
- Gates returning fetch packets into the IQ write port, pulses an IQ clear on redirect, and discards stale in-flight fetch responses.

---
 rtl/iq_fetch_ctrl_pkg.sv | 15 +
 rtl/iq_fetch_ctrl_credit_calc.sv | 34 +++
 rtl/iq_fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_iq_fetch_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/iq_fetch_ctrl_pkg.sv
// Shared state encodings and default sizing for the IQ fetch controller.
// Defaults track the instruction-queue capacity and fetch width.
package iq_fetch_ctrl_pkg;

  localparam int unsigned IQ_FC_IQ_CAP      = 16;
  localparam int unsigned IQ_FC_FETCH_WIDTH = 4;
  localparam int unsigned IQ_FC_MAX_OUT     = 2;

  typedef enum logic [1:0] {
    IQ_FC_RUN   = 2'd0,
    IQ_FC_FLUSH = 2'd1,
    IQ_FC_DRAIN = 2'd2
  } iq_fc_state_e;

endpackage

// File: rtl/iq_fetch_ctrl_credit_calc.sv
// Combinational IQ credit check: free slots after reserving worst-case
// returns for every in-flight fetch, plus the outstanding-limit check.
module iq_credit_calc
  import iq_fetch_ctrl_pkg::*;
#(
  parameter int unsigned IQ_CAP      = IQ_FC_IQ_CAP,
  parameter int unsigned FETCH_WIDTH = IQ_FC_FETCH_WIDTH,
  parameter int unsigned MAX_OUT     = IQ_FC_MAX_OUT,
  parameter int unsigned NW          = $clog2(IQ_CAP) + 1,
  parameter int unsigned OW          = $clog2(MAX_OUT) + 1
) (
  input  logic [NW-1:0] iq_number_i,
  input  logic [OW-1:0] outstanding_i,
  output logic          credit_ok_o,
  output logic          slot_ok_o
);

  // Two spare bits: one for sign, one so the most negative result fits.
  localparam int FW = $clog2(IQ_CAP + FETCH_WIDTH * MAX_OUT) + 2;
  localparam logic signed [FW-1:0] C_TOP = FW'(IQ_CAP - 1);
  localparam logic signed [FW-1:0] C_FW  = FW'(FETCH_WIDTH);

  logic signed [FW-1:0] w_num;
  logic signed [FW-1:0] w_rsv;
  logic signed [FW-1:0] w_free;

  assign w_num  = FW'(iq_number_i);
  assign w_rsv  = FW'(FETCH_WIDTH * outstanding_i);
  assign w_free = C_TOP - w_num - w_rsv;

  assign credit_ok_o = (w_free >= C_FW);
  assign slot_ok_o   = (outstanding_i < OW'(MAX_OUT));

endmodule

// File: rtl/iq_fetch_ctrl.sv
// Credit-based fetch throttle and flush-recovery sequencer for the decode IQ.
// Optional IQ_FETCH_PERF_EN adds stall/drop performance counters.
module iq_fetch_ctrl
  import iq_fetch_ctrl_pkg::*;
#(
  parameter int unsigned IQ_CAP      = IQ_FC_IQ_CAP,
  parameter int unsigned FETCH_WIDTH = IQ_FC_FETCH_WIDTH,
  parameter int unsigned MAX_OUT     = IQ_FC_MAX_OUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  output logic                       fetch_req_o,
  input  logic                       fetch_ready_i,
  input  logic                       resp_valid_i,
  input  logic [$clog2(IQ_CAP):0]    iq_number_i,
  output logic                       iq_valid_o,
  output logic                       iq_flush_o,
  output logic [1:0]                 state_o,
  output logic [$clog2(MAX_OUT):0]   outstanding_o,
  output logic                       err_o
`ifdef IQ_FETCH_PERF_EN
  ,
  output logic [31:0]                perf_stall_o,
  output logic [31:0]                perf_drop_o
`endif
);

  localparam int unsigned NW = $clog2(IQ_CAP) + 1;
  localparam int unsigned OW = $clog2(MAX_OUT) + 1;

  iq_fc_state_e  r_state, w_state_nxt;
  logic [OW-1:0] r_out, w_out_nxt;
  logic          r_err, r_iq_flush;
  logic          w_run, w_credit_ok, w_slot_ok, w_accept, w_resp_ok, w_resp_err;

  iq_credit_calc #(
    .IQ_CAP      (IQ_CAP),
    .FETCH_WIDTH (FETCH_WIDTH),
    .MAX_OUT     (MAX_OUT),
    .NW          (NW),
    .OW          (OW)
  ) u_credit (
    .iq_number_i   (iq_number_i),
    .outstanding_i (r_out),
    .credit_ok_o   (w_credit_ok),
    .slot_ok_o     (w_slot_ok)
  );

  assign w_run       = (r_state == IQ_FC_RUN) && !flush_i && !rst;
  assign fetch_req_o = w_run && w_slot_ok && w_credit_ok;
  assign w_accept    = fetch_req_o && fetch_ready_i;
  assign w_resp_ok   = resp_valid_i && (r_out != '0);
  assign w_resp_err  = resp_valid_i && (r_out == '0);
  assign iq_valid_o  = w_run && w_resp_ok;

  // Stale responses in FLUSH/DRAIN still retire their credit here.
  always_comb begin
    w_out_nxt = r_out;
    case ({w_accept, w_resp_ok})
      2'b10:   w_out_nxt = r_out + OW'(1);
      2'b01:   w_out_nxt = r_out - OW'(1);
      default: w_out_nxt = r_out;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IQ_FC_RUN:   if (flush_i) w_state_nxt = IQ_FC_FLUSH;
      IQ_FC_FLUSH: begin
        if (flush_i)               w_state_nxt = IQ_FC_FLUSH;
        else if (w_out_nxt != '0)  w_state_nxt = IQ_FC_DRAIN;
        else                       w_state_nxt = IQ_FC_RUN;
      end
      IQ_FC_DRAIN: begin
        if (flush_i)               w_state_nxt = IQ_FC_FLUSH;
        else if (w_out_nxt == '0)  w_state_nxt = IQ_FC_RUN;
      end
      default:                     w_state_nxt = IQ_FC_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IQ_FC_RUN;
      r_out      <= '0;
      r_err      <= 1'b0;
      r_iq_flush <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_out      <= w_out_nxt;
      r_err      <= r_err | w_resp_err;
      r_iq_flush <= flush_i;
    end
  end

  assign state_o       = r_state;
  assign outstanding_o = r_out;
  assign err_o         = r_err;
  assign iq_flush_o    = r_iq_flush;

`ifdef IQ_FETCH_PERF_EN
  logic [31:0] r_perf_stall, r_perf_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_drop  <= '0;
    end else begin
      if (w_run && w_slot_ok && !w_credit_ok) r_perf_stall <= r_perf_stall + 32'd1;
      if (resp_valid_i && !iq_valid_o)        r_perf_drop  <= r_perf_drop + 32'd1;
    end
  end

  assign perf_stall_o = r_perf_stall;
  assign perf_drop_o  = r_perf_drop;
`endif

endmodule

// File: tb/tb_iq_fetch_ctrl.sv
// Self-checking bench for iq_fetch_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural flush/credit model.
module tb_iq_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush_i, fetch_ready_i, resp_valid_i;
  logic [4:0] iq_number_i;
  logic       fetch_req_o, iq_valid_o, iq_flush_o, err_o;
  logic [1:0] state_o, outstanding_o;

  int checks = 0;
  int errors = 0;

  // Model: 0=running, 1=flushing, 2=draining stale fetches.
  int m_state, m_out;
  bit m_err, m_iqf;

  iq_fetch_ctrl #(.IQ_CAP(16), .FETCH_WIDTH(4), .MAX_OUT(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .fetch_req_o   (fetch_req_o),
    .fetch_ready_i (fetch_ready_i),
    .resp_valid_i  (resp_valid_i),
    .iq_number_i   (iq_number_i),
    .iq_valid_o    (iq_valid_o),
    .iq_flush_o    (iq_flush_o),
    .state_o       (state_o),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  function automatic bit exp_req();
    int free_slots;
    free_slots = 15 - int'(iq_number_i) - 4 * m_out;
    return !rst && m_state == 0 && !flush_i && m_out < 2 && free_slots >= 4;
  endfunction

  function automatic bit exp_iqv();
    return !rst && resp_valid_i && m_state == 0 && !flush_i && m_out != 0;
  endfunction

  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = exp_req() && fetch_ready_i;
    if (rst) begin
      m_state = 0; m_out = 0; m_err = 0; m_iqf = 0;
    end else begin
      if (resp_valid_i) begin
        if (m_out == 0) m_err = 1;
        else m_out--;
      end
      if (acc) m_out++;
      if (flush_i) m_state = 1;
      else if (m_state != 0) m_state = (m_out == 0) ? 0 : 2;
      m_iqf = flush_i;
    end
    #1;
  endtask

  task automatic set_in(input bit f, input bit rdy, input bit rv, input int num);
    flush_i = f; fetch_ready_i = rdy; resp_valid_i = rv; iq_number_i = 5'(num);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 1, 1, 0);
    tick(); tick();
    checks++; if (fetch_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b expected 0", fetch_req_o); end
    checks++; if (iq_valid_o !== 1'b0) begin errors++; $display("FAIL rst_iqv: got %0b expected 0", iq_valid_o); end
    checks++; if ({state_o, outstanding_o, err_o, iq_flush_o} !== 6'b0) begin
      errors++; $display("FAIL rst_regs: got state=%0d out=%0d err=%0b iqf=%0b expected all 0", state_o, outstanding_o, err_o, iq_flush_o);
    end
    rst = 1'b0;
    set_in(0, 1, 0, 0);
    #1;
  endtask

  task automatic test_fill();
    checks++; if (state_o !== 2'd0 || fetch_req_o !== 1'b1) begin
      errors++; $display("FAIL fill_start: got state=%0d req=%0b expected state=0 req=1", state_o, fetch_req_o);
    end
    tick(); tick();
    checks++; if (outstanding_o !== 2'd2) begin errors++; $display("FAIL fill_out: got %0d expected 2", outstanding_o); end
    checks++; if (fetch_req_o !== 1'b0) begin errors++; $display("FAIL fill_req: got %0b expected 0", fetch_req_o); end
  endtask

  task automatic test_credit();
    set_in(0, 0, 1, 0); #1;
    checks++; if (iq_valid_o !== 1'b1) begin errors++; $display("FAIL credit_drain_iqv: got %0b expected 1", iq_valid_o); end
    tick(); tick();
    set_in(0, 0, 0, 8); #1;
    checks++; if (outstanding_o !== 2'd0 || fetch_req_o !== 1'b1) begin
      errors++; $display("FAIL credit_free7: got out=%0d req=%0b expected out=0 req=1", outstanding_o, fetch_req_o);
    end
    fetch_ready_i = 1'b1; tick();
    fetch_ready_i = 1'b0; #1;
    checks++; if (fetch_req_o !== 1'b0) begin errors++; $display("FAIL credit_free3: got %0b expected 0", fetch_req_o); end
    resp_valid_i = 1'b1; #1;
    checks++; if (iq_valid_o !== 1'b1) begin errors++; $display("FAIL credit_resp_iqv: got %0b expected 1", iq_valid_o); end
    tick();
    set_in(0, 1, 0, 12); #1;
    checks++; if (outstanding_o !== 2'd0 || fetch_req_o !== 1'b0) begin
      errors++; $display("FAIL credit_handover: got out=%0d req=%0b expected out=0 req=0", outstanding_o, fetch_req_o);
    end
  endtask

  task automatic test_flush();
    set_in(0, 1, 0, 0); tick(); tick();
    set_in(1, 0, 0, 0); #1;
    checks++; if (fetch_req_o !== 1'b0) begin errors++; $display("FAIL flush_req: got %0b expected 0", fetch_req_o); end
    tick();
    flush_i = 1'b0; #1;
    checks++; if (iq_flush_o !== 1'b1 || state_o !== 2'd1) begin
      errors++; $display("FAIL flush_pulse: got iqf=%0b state=%0d expected iqf=1 state=1", iq_flush_o, state_o);
    end
    tick();
    checks++; if (state_o !== 2'd2 || iq_flush_o !== 1'b0) begin
      errors++; $display("FAIL flush_drain: got state=%0d iqf=%0b expected state=2 iqf=0", state_o, iq_flush_o);
    end
    resp_valid_i = 1'b1; #1;
    checks++; if (iq_valid_o !== 1'b0) begin errors++; $display("FAIL flush_stale1: got %0b expected 0", iq_valid_o); end
    tick();
    checks++; if (iq_valid_o !== 1'b0 || state_o !== 2'd2) begin
      errors++; $display("FAIL flush_stale2: got iqv=%0b state=%0d expected iqv=0 state=2", iq_valid_o, state_o);
    end
    tick();
    resp_valid_i = 1'b0; #1;
    checks++; if (state_o !== 2'd0 || outstanding_o !== 2'd0 || fetch_req_o !== 1'b1) begin
      errors++; $display("FAIL flush_resume: got state=%0d out=%0d req=%0b expected 0 0 1", state_o, outstanding_o, fetch_req_o);
    end
  endtask

  task automatic test_same_cycle();
    set_in(0, 1, 0, 0); tick();
    resp_valid_i = 1'b1; #1;
    checks++; if (iq_valid_o !== 1'b1 || fetch_req_o !== 1'b1) begin
      errors++; $display("FAIL same_comb: got iqv=%0b req=%0b expected 1 1", iq_valid_o, fetch_req_o);
    end
    tick();
    checks++; if (outstanding_o !== 2'd1) begin errors++; $display("FAIL same_out: got %0d expected 1", outstanding_o); end
    set_in(0, 0, 1, 0); tick();
    resp_valid_i = 1'b0; #1;
  endtask

  task automatic test_err();
    set_in(0, 0, 1, 0); #1;
    checks++; if (iq_valid_o !== 1'b0) begin errors++; $display("FAIL err_iqv: got %0b expected 0", iq_valid_o); end
    tick();
    resp_valid_i = 1'b0;
    checks++; if (err_o !== 1'b1 || outstanding_o !== 2'd0) begin
      errors++; $display("FAIL err_set: got err=%0b out=%0d expected err=1 out=0", err_o, outstanding_o);
    end
    tick(); tick();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b expected 1", err_o); end
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b expected 0", err_o); end
  endtask

  task automatic test_back_to_back();
    set_in(0, 1, 0, 0); tick(); tick();
    set_in(1, 0, 0, 0); tick();
    tick();
    checks++; if (iq_flush_o !== 1'b1 || state_o !== 2'd1) begin
      errors++; $display("FAIL b2b_flush2: got iqf=%0b state=%0d expected 1 1", iq_flush_o, state_o);
    end
    flush_i = 1'b0; tick();
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL b2b_drain: got %0d expected 2", state_o); end
    flush_i = 1'b1; tick();
    checks++; if (iq_flush_o !== 1'b1 || state_o !== 2'd1) begin
      errors++; $display("FAIL b2b_drain_flush: got iqf=%0b state=%0d expected 1 1", iq_flush_o, state_o);
    end
    set_in(0, 0, 0, 0); tick();
    resp_valid_i = 1'b1; tick(); tick();
    resp_valid_i = 1'b0; #1;
    checks++; if (state_o !== 2'd0 || outstanding_o !== 2'd0) begin
      errors++; $display("FAIL b2b_recover: got state=%0d out=%0d expected 0 0", state_o, outstanding_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      flush_i       = ($urandom_range(0, 9) == 0);
      fetch_ready_i = 1'($urandom_range(0, 1));
      resp_valid_i  = (m_out > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
      iq_number_i   = 5'($urandom_range(0, 16));
      #1;
      checks++; if (fetch_req_o !== exp_req() || iq_valid_o !== exp_iqv()) begin
        errors++; $display("FAIL rnd_comb[%0d]: got req=%0b iqv=%0b expected req=%0b iqv=%0b", i, fetch_req_o, iq_valid_o, exp_req(), exp_iqv());
      end
      tick();
      checks++; if (int'(state_o) != m_state || int'(outstanding_o) != m_out || err_o !== m_err || iq_flush_o !== m_iqf) begin
        errors++; $display("FAIL rnd_regs[%0d]: got state=%0d out=%0d err=%0b iqf=%0b expected %0d %0d %0b %0b",
                           i, state_o, outstanding_o, err_o, iq_flush_o, m_state, m_out, m_err, m_iqf);
      end
    end
    rst = 1'b0;
    set_in(0, 0, 0, 0);
  endtask

  initial begin
    m_state = 0; m_out = 0; m_err = 0; m_iqf = 0;
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    test_reset();
    test_fill();
    test_credit();
    test_flush();
    test_same_cycle();
    test_err();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
